dpram_sc_be: RTL and testbench

Single-clock, parametrised dual-port RAM with two ports: A is a read/write port with byte enables, B is a read-only port.
- Adds a post-reset clear sequencer, selectable read-during-write behaviour, a configurable read latency with valid strobes, and a collision flag.
- Sits between the frame/pixel producers and the display/readout logic as the general buffer for new designs.
- Memory is sized exactly to 2**ADR_WIDTH words.

---
 rtl/dpram_pkg.sv | 23 ++
 rtl/dpram_sc_be_if.sv | 36 +++
 rtl/dpram_clear_seq.sv | 42 ++++
 rtl/dpram_sc_be.sv | 168 ++++++++++++++++
 tb/tb_dpram_sc_be.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// Shared constants, clear-FSM state type and lane helpers for dpram_sc_be.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dpram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    function automatic int lane_cnt(input int dat_width);
        return dat_width / 8;
    endfunction

    // Even parity: stored bit makes the byte plus parity an even count of ones.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dpram_sc_be_if.sv
// Port bundle for dpram_sc_be: byte-enabled R/W port A, read-only port B, status.
// Latency: n/a (wiring only).
// Backpressure: none; requests are accepted every cycle outside the clear.
interface dpram_sc_be_if #(
    parameter int ADR_WIDTH = 13,
    parameter int DAT_WIDTH = 16
);
    localparam int NB = DAT_WIDTH / 8;

    logic                 init_busy;
    logic                 en_a;
    logic                 we_a;
    logic [NB-1:0]        be_a;
    logic [ADR_WIDTH-1:0] adr_a;
    logic [DAT_WIDTH-1:0] dat_a;
    logic [DAT_WIDTH-1:0] dat_a_out;
    logic                 vld_a;
    logic                 en_b;
    logic                 re_b;
    logic [ADR_WIDTH-1:0] adr_b;
    logic [DAT_WIDTH-1:0] dat_b;
    logic                 vld_b;
    logic                 collision;
    logic                 par_err_b;

    modport master (
        output en_a, we_a, be_a, adr_a, dat_a, en_b, re_b, adr_b,
        input  init_busy, dat_a_out, vld_a, dat_b, vld_b, collision, par_err_b
    );

    modport slave (
        input  en_a, we_a, be_a, adr_a, dat_a, en_b, re_b, adr_b,
        output init_busy, dat_a_out, vld_a, dat_b, vld_b, collision, par_err_b
    );

endinterface

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, writing zero.
// Latency: DEPTH cycles from reset release to init_busy low.
// Backpressure: none; the RAM write port is owned by this block while busy.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADR_WIDTH      = 13,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 clr_we,
    output logic [ADR_WIDTH-1:0] clr_adr,
    output logic                 init_busy
);

    clr_state_t           state;
    logic [ADR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt       <= '0;
            init_busy <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clr_we  = (state == CLEAR);
    assign clr_adr = cnt;

endmodule

// File: rtl/dpram_sc_be.sv
// Single-clock dual-port RAM, byte-enabled port A, read port B; DPRAM_PARITY_EN adds lane parity.
// Latency: RD_LAT (1 or 2) cycles for reads; collision flag 1 cycle after the clash.
// Backpressure: none; all requests are dropped while init_busy is high.
module dpram_sc_be
    import dpram_pkg::*;
#(
    parameter int ADR_WIDTH      = 13,
    parameter int DAT_WIDTH      = 16,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = ""
) (
    input  logic            clk,
    input  logic            rst_n,
    dpram_sc_be_if.slave    bus
);

    localparam int NB    = lane_cnt(DAT_WIDTH);
    localparam int DEPTH = 2 ** ADR_WIDTH;

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    logic                 clr_we;
    logic [ADR_WIDTH-1:0] clr_adr;
    logic                 init_busy;

    dpram_clear_seq #(
        .ADR_WIDTH      (ADR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_adr   (clr_adr),
        .init_busy (init_busy)
    );

    assign bus.init_busy = init_busy;

    logic wr_a, rd_a, rd_b, coll;
    assign wr_a = ~clr_we & bus.en_a & bus.we_a;
    assign rd_a = ~clr_we & bus.en_a & ~bus.we_a;
    assign rd_b = ~clr_we & bus.en_b & bus.re_b;
    assign coll = wr_a & (|bus.be_a) & rd_b & (bus.adr_a == bus.adr_b);

    // The clear sequencer owns the write port while it runs.
    logic                 mem_we;
    logic [NB-1:0]        mem_be;
    logic [ADR_WIDTH-1:0] mem_adr;
    logic [DAT_WIDTH-1:0] mem_din;
    assign mem_we  = clr_we | (wr_a & (|bus.be_a));
    assign mem_be  = clr_we ? {NB{1'b1}} : bus.be_a;
    assign mem_adr = clr_we ? clr_adr : bus.adr_a;
    assign mem_din = clr_we ? '0 : bus.dat_a;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) mem[mem_adr][i*8 +: 8] <= mem_din[i*8 +: 8];
            end
        end
    end

    logic [DAT_WIDTH-1:0] rd_a_word, rd_b_old, rd_b_mrg, rd_b_word;
    assign rd_a_word = mem[bus.adr_a];
    assign rd_b_old  = mem[bus.adr_b];

    always_comb begin
        rd_b_mrg = rd_b_old;
        for (int i = 0; i < NB; i++) begin
            if (bus.be_a[i]) rd_b_mrg[i*8 +: 8] = bus.dat_a[i*8 +: 8];
        end
    end

    assign rd_b_word = (RDW_MODE == RDW_NEW && coll) ? rd_b_mrg : rd_b_old;

    logic perr_now;

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] din_par, rd_par, rd_calc;

    always_comb begin
        din_par = '0;
        for (int i = 0; i < NB; i++) din_par[i] = byte_par(mem_din[i*8 +: 8]);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) par_mem[mem_adr][i] <= din_par[i];
            end
        end
    end

    // Forwarded lanes carry the parity of the incoming byte, matching the merged data.
    always_comb begin
        rd_par  = par_mem[bus.adr_b];
        rd_calc = '0;
        for (int i = 0; i < NB; i++) begin
            if (RDW_MODE == RDW_NEW && coll && bus.be_a[i]) rd_par[i] = din_par[i];
            rd_calc[i] = byte_par(rd_b_word[i*8 +: 8]);
        end
    end

    assign perr_now = |(rd_par ^ rd_calc);
`else
    assign perr_now = 1'b0;
`endif

    logic [DAT_WIDTH-1:0] a_dat1, b_dat1;
    logic                 a_vld1, b_vld1, b_perr1, coll_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dat1  <= '0;
            a_vld1  <= 1'b0;
            b_dat1  <= '0;
            b_vld1  <= 1'b0;
            b_perr1 <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            a_vld1  <= rd_a;
            b_vld1  <= rd_b;
            b_perr1 <= rd_b & perr_now;
            coll_q  <= coll;
            if (rd_a) a_dat1 <= rd_a_word;
            if (rd_b) b_dat1 <= rd_b_word;
        end
    end

    assign bus.collision = coll_q;

    if (RD_LAT == 2) begin : g_lat2
        logic [DAT_WIDTH-1:0] a_dat2, b_dat2;
        logic                 a_vld2, b_vld2, b_perr2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_dat2  <= '0;
                a_vld2  <= 1'b0;
                b_dat2  <= '0;
                b_vld2  <= 1'b0;
                b_perr2 <= 1'b0;
            end else begin
                a_vld2  <= a_vld1;
                b_vld2  <= b_vld1;
                b_perr2 <= b_perr1;
                if (a_vld1) a_dat2 <= a_dat1;
                if (b_vld1) b_dat2 <= b_dat1;
            end
        end

        assign bus.dat_a_out = a_dat2;
        assign bus.vld_a     = a_vld2;
        assign bus.dat_b     = b_dat2;
        assign bus.vld_b     = b_vld2;
        assign bus.par_err_b = b_perr2;
    end else begin : g_lat1
        assign bus.dat_a_out = a_dat1;
        assign bus.vld_a     = a_vld1;
        assign bus.dat_b     = b_dat1;
        assign bus.vld_b     = b_vld1;
        assign bus.par_err_b = b_perr1;
    end

endmodule

// File: tb/tb_dpram_sc_be.sv
// Bench for dpram_sc_be: u0 = RD_LAT 1 / old-data RDW, u1 = RD_LAT 2 / new-data RDW.
// Both instances see identical stimulus; expectations are hand-computed per instance.
module tb_dpram_sc_be;

    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpram_sc_be_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) if0 ();
    dpram_sc_be_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) if1 ();

    dpram_sc_be #(
        .ADR_WIDTH(AW), .DAT_WIDTH(DW), .RD_LAT(1), .RDW_MODE(0),
        .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

    dpram_sc_be #(
        .ADR_WIDTH(AW), .DAT_WIDTH(DW), .RD_LAT(2), .RDW_MODE(1),
        .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    typedef struct {
        bit          ea;
        bit          wa;
        logic [1:0]  be;
        logic [3:0]  aa;
        logic [15:0] da;
        bit          eb;
        logic [3:0]  ab;
        logic [15:0] exp_a;
        logic [15:0] exp_b0;
        logic [15:0] exp_b1;
        bit          exp_col;
    } vec_t;

    localparam int NV = 15;
    vec_t        vt [NV];
    logic [15:0] bexp [16];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt0, cnt1, vseen;
    logic [1:0]  pv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ea, input bit wa, input logic [1:0] be, input logic [3:0] aa,
                         input logic [15:0] da, input bit eb, input logic [3:0] ab);
        if0.en_a = ea; if0.we_a = wa; if0.be_a = be; if0.adr_a = aa; if0.dat_a = da;
        if0.en_b = eb; if0.re_b = eb; if0.adr_b = ab;
        if1.en_a = ea; if1.we_a = wa; if1.be_a = be; if1.adr_a = aa; if1.dat_a = da;
        if1.en_b = eb; if1.re_b = eb; if1.adr_b = ab;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
    endtask

    // Back-to-back B reads of addresses 0..num-1, expected data in bexp.
    task automatic b_burst(input int num);
        for (int n = 0; n <= num + 1; n++) begin
            @(negedge clk);
            if (n >= 1) begin
                chk("u0_burst_vld", {31'b0, if0.vld_b}, {31'b0, (n - 1) < num});
                if ((n - 1) < num) chk("u0_burst_dat", {16'b0, if0.dat_b}, {16'b0, bexp[n-1]});
                chk("u1_burst_vld", {31'b0, if1.vld_b}, {31'b0, (n >= 2) && ((n - 2) < num)});
                if ((n >= 2) && ((n - 2) < num))
                    chk("u1_burst_dat", {16'b0, if1.dat_b}, {16'b0, bexp[n-2]});
            end
            if (n < num) drive(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, n[3:0]);
            else         idle();
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy0", {31'b0, if0.init_busy}, 1);
        chk("rst_busy1", {31'b0, if1.init_busy}, 1);
        chk("rst_vld0",  {30'b0, if0.vld_a, if0.vld_b}, 0);
        chk("rst_vld1",  {30'b0, if1.vld_a, if1.vld_b}, 0);
        chk("rst_dat0",  {if0.dat_a_out, if0.dat_b}, 0);
        chk("rst_dat1",  {if1.dat_a_out, if1.dat_b}, 0);
        chk("rst_flags", {28'b0, if0.collision, if0.par_err_b, if1.collision, if1.par_err_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ra;
        //          ea wa be     aa    da        eb ab    exp_a     exp_b0    exp_b1    col
        vt[0]  = '{1, 1, 2'b11, 4'h5, 16'h1234, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[1]  = '{1, 1, 2'b11, 4'h9, 16'hAAAA, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[2]  = '{0, 0, 2'b00, 4'h0, 16'h0000, 1, 4'h5, 16'h0000, 16'h1234, 16'h1234, 0};
        vt[3]  = '{1, 1, 2'b01, 4'h5, 16'hABCD, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[4]  = '{0, 0, 2'b00, 4'h0, 16'h0000, 1, 4'h5, 16'h0000, 16'h12CD, 16'h12CD, 0};
        vt[5]  = '{1, 1, 2'b11, 4'h9, 16'h5555, 1, 4'h9, 16'h0000, 16'hAAAA, 16'h5555, 1};
        vt[6]  = '{0, 0, 2'b00, 4'h0, 16'h0000, 1, 4'h9, 16'h0000, 16'h5555, 16'h5555, 0};
        vt[7]  = '{1, 1, 2'b00, 4'h9, 16'hFFFF, 1, 4'h9, 16'h0000, 16'h5555, 16'h5555, 0};
        vt[8]  = '{1, 0, 2'b00, 4'h5, 16'h0000, 0, 4'h0, 16'h12CD, 16'h0000, 16'h0000, 0};
        vt[9]  = '{1, 1, 2'b10, 4'h3, 16'hBEEF, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[10] = '{0, 0, 2'b00, 4'h0, 16'h0000, 1, 4'h3, 16'h0000, 16'hBE00, 16'hBE00, 0};
        vt[11] = '{1, 1, 2'b10, 4'h9, 16'h7700, 1, 4'h9, 16'h0000, 16'h5555, 16'h7755, 1};
        vt[12] = '{1, 1, 2'b11, 4'h2, 16'h2C2C, 1, 4'h7, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[13] = '{0, 0, 2'b00, 4'h0, 16'h0000, 1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[14] = '{1, 0, 2'b00, 4'h9, 16'h0000, 1, 4'h5, 16'h7755, 16'h12CD, 16'h12CD, 0};

        idle();
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals();

        // Partial clear, then reset again after 7 cleared words.
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        chk("midclear_busy0", {31'b0, if0.init_busy}, 1);
        chk("midclear_busy1", {31'b0, if1.init_busy}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // Requests issued while busy must be dropped.
        cnt0 = 0; cnt1 = 0; vseen = 0;
        for (int c = 0; c < 30; c++) begin
            if (if0.init_busy) cnt0++;
            if (if1.init_busy) cnt1++;
            if (if0.vld_b || if1.vld_b || if0.vld_a || if1.vld_a) vseen++;
            if (if0.init_busy) drive(1'b1, 1'b1, 2'b11, 4'h4, 16'hFFFF, 1'b1, 4'h4);
            else               idle();
            @(negedge clk);
        end
        chk("busy_cycles0", cnt0, 16);
        chk("busy_cycles1", cnt1, 16);
        chk("vld_during_clear", vseen, 0);

        for (int i = 0; i < 16; i++) bexp[i] = 16'h0000;
        b_burst(16);

        for (int v = 0; v < NV; v++) begin
            ra = vt[v].ea & ~vt[v].wa;
            @(negedge clk);
            drive(vt[v].ea, vt[v].wa, vt[v].be, vt[v].aa, vt[v].da, vt[v].eb, vt[v].ab);
            @(negedge clk);
            idle();
            chk("col0_pulse", {31'b0, if0.collision}, {31'b0, vt[v].exp_col});
            chk("col1_pulse", {31'b0, if1.collision}, {31'b0, vt[v].exp_col});
            chk("u0_vld_b",   {31'b0, if0.vld_b}, {31'b0, vt[v].eb});
            if (vt[v].eb) chk("u0_dat_b", {16'b0, if0.dat_b}, {16'b0, vt[v].exp_b0});
            chk("u0_vld_a",   {31'b0, if0.vld_a}, {31'b0, ra});
            if (ra) chk("u0_dat_a", {16'b0, if0.dat_a_out}, {16'b0, vt[v].exp_a});
            chk("u0_perr",    {31'b0, if0.par_err_b}, 0);
            chk("u1_early",   {30'b0, if1.vld_a, if1.vld_b}, 0);
            @(negedge clk);
            chk("col_clear",  {30'b0, if0.collision, if1.collision}, 0);
            chk("u1_vld_b",   {31'b0, if1.vld_b}, {31'b0, vt[v].eb});
            if (vt[v].eb) chk("u1_dat_b", {16'b0, if1.dat_b}, {16'b0, vt[v].exp_b1});
            chk("u1_vld_a",   {31'b0, if1.vld_a}, {31'b0, ra});
            if (ra) chk("u1_dat_a", {16'b0, if1.dat_a_out}, {16'b0, vt[v].exp_a});
            chk("u1_perr",    {31'b0, if1.par_err_b}, 0);
            chk("u0_pulse",   {30'b0, if0.vld_a, if0.vld_b}, 0);
        end

        // Output data holds after the last read.
        chk("u0_hold_b", {16'b0, if0.dat_b}, {16'b0, 16'h12CD});
        chk("u1_hold_a", {16'b0, if1.dat_a_out}, {16'b0, 16'h7755});

        // Back-to-back writes then back-to-back reads of 0..3.
        bexp[0] = 16'h0A0A; bexp[1] = 16'h1B1B; bexp[2] = 16'h2C2C; bexp[3] = 16'h3D3D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 2'b11, i[3:0], bexp[i], 1'b0, 4'h0);
        end
        @(negedge clk);
        idle();
        b_burst(4);

`ifdef DPRAM_PARITY_EN
        pv = u0.par_mem[3];
        force u0.par_mem[3] = pv ^ 2'b01;
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h3);
        @(negedge clk);
        idle();
        chk("par_vld",   {31'b0, if0.vld_b}, 1);
        chk("par_err",   {31'b0, if0.par_err_b}, 1);
        @(negedge clk);
        chk("par_clear", {31'b0, if0.par_err_b}, 0);
        release u0.par_mem[3];
`else
        pv = 2'b00;
        chk("par_tied", {30'b0, if0.par_err_b, if1.par_err_b}, {30'b0, pv});
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
